// File: rtl/sigbuff_pkg.sv
// Shared types and constants for the signal buffer controller.
package sigbuff_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    SWAP = 2'd2
  } state_t;

  // input_mux encodings
  localparam logic SRC_LVL = 1'b0;
  localparam logic SRC_FB  = 1'b1;

endpackage

// File: rtl/sigbuff_bank.sv
// One sample bank: simple dual-port RAM with a registered read port.
module sigbuff_bank #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [1 << ADDR_WIDTH];

  // Write port; contents deliberately survive reset.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Registered read port, holds its last value when idle.
  always_ff @(posedge clock) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/sigbuff_ctrl.sv
// Ping-pong sample buffer: replays one bank to the FIR while filling the other,
// swapping banks whenever the iteration number changes.
module sigbuff_ctrl
  import sigbuff_pkg::*;
#(
  parameter int unsigned DATA_WIDTH         = 16,
  parameter int unsigned MAX_SAMPLES_IN_RAM = 255,
  parameter int unsigned ADDR_WIDTH         = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [4:0]            iter_num,
  input  logic                  input_mux,
  input  logic                  input_enable,
  input  logic                  output_enable,
  input  logic [DATA_WIDTH-1:0] lvl_data,
  input  logic                  lvl_valid,
  input  logic [DATA_WIDTH-1:0] fb_data,
  input  logic                  fb_valid,
  output logic [DATA_WIDTH-1:0] fir_data,
  output logic                  fir_valid,
  output logic [ADDR_WIDTH:0]   frame_len,
  output logic                  overrun,
  output logic                  underrun
);

  localparam int unsigned CntW = ADDR_WIDTH + 1;
  localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_SAMPLES_IN_RAM);

  state_t                state, state_next;
  logic [4:0]            iter_num_q;
  logic                  bank_sel;
  logic [CntW-1:0]       wr_count;
  logic [CntW-1:0]       rd_addr;
  logic                  rd_pend_q, rd_zero_q, rd_bank_q;
  logic                  src_valid;
  logic [DATA_WIDTH-1:0] src_data;
  logic                  wr_req, wr_fire, wr_drop;
  logic                  rd_req, rd_fire, rd_under;
  logic [DATA_WIDTH-1:0] q0, q1;

  // Source mux and request qualification.
  always_comb begin
    src_valid = (input_mux == SRC_FB) ? fb_valid : lvl_valid;
    src_data  = (input_mux == SRC_FB) ? fb_data  : lvl_data;
    wr_req    = input_enable && src_valid;
    wr_fire   = wr_req && (state == RUN) && (wr_count < MaxCnt);
    // Dropped writes: any request during SWAP, or a full write bank in RUN.
    wr_drop   = wr_req && ((state == SWAP) || ((state == RUN) && (wr_count >= MaxCnt)));
    rd_req    = output_enable && (state == RUN);
    rd_fire   = rd_req && (rd_addr < frame_len);
    rd_under  = rd_req && !(rd_addr < frame_len);
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (input_enable || output_enable) state_next = RUN;
      RUN:     if (iter_num != iter_num_q) state_next = SWAP;
      SWAP:    state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  // State, bank select, counters and sticky flags.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      iter_num_q <= '0;
      bank_sel   <= 1'b0;
      wr_count   <= '0;
      rd_addr    <= '0;
      frame_len  <= '0;
      overrun    <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      state      <= state_next;
      iter_num_q <= iter_num;
      if (state == SWAP) begin
        bank_sel  <= ~bank_sel;
        frame_len <= wr_count;
        wr_count  <= '0;
        rd_addr   <= '0;
        underrun  <= 1'b0;
        // A write arriving in the swap cycle wins over the clear.
        overrun   <= wr_drop;
      end else begin
        if (wr_fire)  wr_count <= wr_count + CntW'(1);
        if (rd_fire)  rd_addr  <= rd_addr + CntW'(1);
        if (wr_drop)  overrun  <= 1'b1;
        if (rd_under) underrun <= 1'b1;
      end
    end
  end

  // Read pipeline: RAM stage then output register; underruns ride the same depth.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_pend_q <= 1'b0;
      rd_zero_q <= 1'b0;
      rd_bank_q <= 1'b0;
      fir_valid <= 1'b0;
      fir_data  <= '0;
    end else begin
      rd_pend_q <= rd_req;
      rd_zero_q <= rd_under;
      rd_bank_q <= bank_sel;
      fir_valid <= rd_pend_q;
      fir_data  <= rd_zero_q ? '0 : (rd_bank_q ? q1 : q0);
    end
  end

  // Bank 0 is read when bank_sel = 0 and written when bank_sel = 1.
  sigbuff_bank #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_bank0 (
    .clock  (clock),
    .wr_en  (wr_fire && bank_sel),
    .wr_addr(wr_count[ADDR_WIDTH-1:0]),
    .wr_data(src_data),
    .rd_en  (rd_fire && !bank_sel),
    .rd_addr(rd_addr[ADDR_WIDTH-1:0]),
    .rd_data(q0)
  );

  sigbuff_bank #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_bank1 (
    .clock  (clock),
    .wr_en  (wr_fire && !bank_sel),
    .wr_addr(wr_count[ADDR_WIDTH-1:0]),
    .wr_data(src_data),
    .rd_en  (rd_fire && bank_sel),
    .rd_addr(rd_addr[ADDR_WIDTH-1:0]),
    .rd_data(q1)
  );

endmodule

// File: doc/sigbuff_ctrl.md
# sigbuff_ctrl

Signal buffer controller for the iterative reconstruction loop. Owns a two-bank sample RAM operated ping-pong: one bank is replayed to the FIR front end while the other collects the next iteration's input, either fresh level-generator samples or hard-limiter feedback. It is driven by the iteration controller's sigbuff signals and swaps banks on every iteration-number change.

## Interface
- DATA_WIDTH, 16, sample width in both banks
- MAX_SAMPLES_IN_RAM, 255, bank depth in samples
- ADDR_WIDTH, 8, bank address width; must satisfy 2**ADDR_WIDTH >= MAX_SAMPLES_IN_RAM

- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- iter_num  in  5  current iteration index from the iteration controller
- input_mux  in  1  write source: 0 = level generator, 1 = limiter feedback
- input_enable  in  1  write permission
- output_enable  in  1  read request for one sample this cycle
- lvl_data / lvl_valid  in  DATA_WIDTH / 1  level-generator sample
- fb_data / fb_valid  in  DATA_WIDTH / 1  limiter feedback sample
- fir_data  out  DATA_WIDTH  replayed sample to the FIR driver
- fir_valid  out  1  fir_data qualifier
- frame_len  out  ADDR_WIDTH+1  samples available in the read bank
- overrun  out  1  sticky: write dropped (bank full or SWAP cycle)
- underrun  out  1  sticky: read past frame_len

## Operation
- State machine:
  - IDLE: after reset. Goes to RUN when input_enable or output_enable is high.
  - RUN: normal operation. Goes to SWAP when iter_num != iter_num_q, where iter_num_q is iter_num registered each cycle.
  - SWAP: lasts exactly 1 cycle, then RUN.
- SWAP actions:
  - bank_sel toggles.
  - frame_len <= wr_count, the count of the bank just written.
  - wr_addr, wr_count and rd_addr clear to 0.
  - overrun and underrun clear.
  - Reads and writes are suppressed. A write request arriving in SWAP is dropped and sets overrun.
- Read bank is bank_sel; write bank is ~bank_sel.
- Write:
  - Fires when all hold: input_enable, selected valid (lvl_valid when input_mux=0, fb_valid when input_mux=1), state RUN, wr_count < MAX_SAMPLES_IN_RAM.
  - Stores the selected data at wr_addr; wr_addr and wr_count increment.
  - When wr_count == MAX_SAMPLES_IN_RAM, the write is dropped and overrun is set.
- Read:
  - Fires when output_enable is high and state is RUN.
  - If rd_addr < frame_len: issue a bank read at rd_addr, then rd_addr increments.
  - Otherwise: fir_data = 0 with fir_valid still asserted, underrun set, rd_addr holds.
- Simultaneous read and write in the same cycle always target different banks, so there is no conflict.
- An iter_num change while in IDLE stores iter_num_q only; no swap occurs.
- Reset mid-operation, all asynchronous:
  - bank_sel = 0, all counters = 0, frame_len = 0, state IDLE.
  - RAM contents are not cleared.

## Timing
- Reset values: fir_data 0, fir_valid 0, frame_len 0, overrun 0, underrun 0.
- Read latency is 2 cycles from output_enable to fir_valid/fir_data: 1 cycle synchronous RAM plus 1 output register. This is fixed, including for underrun reads, whose zero output is pipelined to the same depth.
- Write takes effect at the clock edge of the request cycle; data is readable after the next bank swap.
- SWAP occurs on the cycle after the iter_num change is seen. The first post-swap read can be requested in the cycle after SWAP.
- overrun and underrun are registered and assert 1 cycle after the offending request.
- No backpressure: lvl and fb sources have no ready signal. Flow control is the iteration controller's job through input_enable and output_enable.

## Structure
- Package sigbuff_pkg holds:
  - state enum: IDLE, RUN, SWAP
  - source-select constants: SRC_LVL = 0, SRC_FB = 1
- Sub-module sigbuff_bank: single-clock simple dual-port RAM, one write port and one registered read port, parameterised by DATA_WIDTH and ADDR_WIDTH. Instantiated twice.
- Top level contains the FSM, address/count logic, source mux, read-data mux selected by bank_sel delayed 1 cycle, and the output register.

## Test plan
- Reset then fill: input_mux=0, input_enable=1, 10 lvl_valid samples 1..10, iter_num 0→1 -> SWAP 1 cycle later; frame_len=10. Then 10 output_enable pulses -> fir_data 1..10, each 2 cycles after its request.
- Feedback path: during replay, input_mux=1, fb samples 100..109; iter_num 1→2 -> frame_len=10, replay gives 100..109, and the bank_sel sequence is 0,1,0.
- Overrun: write 256 samples with MAX_SAMPLES_IN_RAM=255 -> first 255 stored, overrun=1 one cycle after the 256th request, wr_count=255; overrun clears on next SWAP.
- Underrun: frame_len=3, 5 reads -> fir_data 1,2,3,0,0, fir_valid high for all 5, underrun=1 after the 4th request.
- Simultaneous events: lvl_valid held continuously across an iter_num change -> the SWAP-cycle sample is dropped, overrun=1, the next sample lands at wr_addr 0 of the new bank.
- Async reset asserted mid-replay between clock edges -> outputs 0 immediately; after release, state IDLE and frame_len=0.
